// File: rtl/vend_sequencer.sv
// Vending machine sequencer: merges two coin slots into one credit count, drives the
// dispense handshake and returns surplus, cancelled or timed-out credit as change pulses.
module vend_sequencer #(
    parameter int PRICE       = 4,
    parameter int MAX_CREDIT  = 7,
    parameter int CREDIT_W    = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                cancel,
    input  logic                disp_ready,
    input  logic                disp_done,
    output logic                disp_req,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int CW      = CREDIT_W + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYC);

    localparam logic [CW-1:0]      MAXC   = CW'(MAX_CREDIT);
    localparam logic [CW-1:0]      PRICEC = CW'(PRICE);
    localparam logic [CW-1:0]      ONE    = CW'(1);
    localparam logic [CW-1:0]      TWO    = CW'(2);
    localparam logic [TIMER_W-1:0] TLAST  = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        VEND,
        WAIT_DONE,
        REFUND
    } state_t;

    state_t state, stateNext;

    logic [CW-1:0]      creditReg, creditNext, afterA, afterB;
    logic [TIMER_W-1:0] timer, timerNext;
    logic               coinOk, acceptA, acceptB, anyAccept;
    logic               rejectNext, pulseNext, reqNext, busyNext;

    // One extra credit bit lets credit+2 be compared against MAX_CREDIT without wrapping.
    always_comb begin
        coinOk     = (state == IDLE) || (state == COLLECT);
        acceptA    = coinOk && coin_a && ((creditReg + ONE) <= MAXC);
        afterA     = acceptA ? (creditReg + ONE) : creditReg;
        acceptB    = coinOk && coin_b && ((afterA + TWO) <= MAXC);
        afterB     = acceptB ? (afterA + TWO) : afterA;
        anyAccept  = acceptA || acceptB;
        rejectNext = (coin_a && !acceptA) || (coin_b && !acceptB);

        stateNext  = state;
        creditNext = afterB;
        timerNext  = timer;
        pulseNext  = 1'b0;

        case (state)
            IDLE: begin
                if (anyAccept) begin
                    stateNext = COLLECT;
                    timerNext = '0;
                end
            end
            COLLECT: begin
                timerNext = anyAccept ? '0 : (timer + TIMER_W'(1));
                // A coin counts as activity, so it also suppresses the timeout that cycle.
                if (cancel) begin
                    stateNext = REFUND;
                    timerNext = '0;
                end else if (afterB >= PRICEC) begin
                    stateNext = VEND;
                    timerNext = '0;
                end else if (!anyAccept && (timer == TLAST)) begin
                    stateNext = REFUND;
                    timerNext = '0;
                end
            end
            VEND: begin
                if (disp_ready) begin
                    creditNext = creditReg - PRICEC;
                    stateNext  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (disp_done) begin
                    stateNext = (creditReg != '0) ? REFUND : IDLE;
                end
            end
            REFUND: begin
                if (creditReg != '0) begin
                    creditNext = creditReg - ONE;
                    pulseNext  = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext  = IDLE;
                creditNext = '0;
                timerNext  = '0;
            end
        endcase

        reqNext  = (stateNext == VEND);
        busyNext = (stateNext == VEND) || (stateNext == WAIT_DONE) || (stateNext == REFUND);
    end

    // All outputs come from flops computed off the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            creditReg    <= '0;
            timer        <= '0;
            disp_req     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            credit       <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= stateNext;
            creditReg    <= creditNext;
            timer        <= timerNext;
            disp_req     <= reqNext;
            change_pulse <= pulseNext;
            coin_reject  <= rejectNext;
            credit       <= creditNext[CREDIT_W-1:0];
            busy         <= busyNext;
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: two instances (PRICE 4 and PRICE 7) share the stimulus and are
// compared every cycle against a per-instance behavioural model of the vending rules.
module tb_vend_sequencer;

    localparam int TOUT = 12;
    localparam int MAXC = 7;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_VEND    = 2;
    localparam int P_WAIT    = 3;
    localparam int P_REFUND  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic coin_a = 1'b0, coin_b = 1'b0, cancel = 1'b0, disp_ready = 1'b0, disp_done = 1'b0;

    logic       req0, pulse0, rej0, busy0;
    logic [2:0] credit0;
    logic       req1, pulse1, rej1, busy1;
    logic [2:0] credit1;

    int total = 0;
    int bad   = 0;

    int price [2] = '{4, 7};
    int mPhase[2];
    int mCredit[2];
    int mIdle[2];
    int eReq[2], ePulse[2], eRej[2], eBusy[2];

    int pulseSeen, reqSeen, rejSeen;

    vend_sequencer #(.PRICE(4), .MAX_CREDIT(MAXC), .CREDIT_W(3), .TIMEOUT_CYC(TOUT)) dut0 (
        .clock(clock), .reset(reset), .coin_a(coin_a), .coin_b(coin_b), .cancel(cancel),
        .disp_ready(disp_ready), .disp_done(disp_done), .disp_req(req0),
        .change_pulse(pulse0), .coin_reject(rej0), .credit(credit0), .busy(busy0)
    );

    vend_sequencer #(.PRICE(7), .MAX_CREDIT(MAXC), .CREDIT_W(3), .TIMEOUT_CYC(TOUT)) dut1 (
        .clock(clock), .reset(reset), .coin_a(coin_a), .coin_b(coin_b), .cancel(cancel),
        .disp_ready(disp_ready), .disp_done(disp_done), .disp_req(req1),
        .change_pulse(pulse1), .coin_reject(rej1), .credit(credit1), .busy(busy1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mPhase[k] = P_IDLE; mCredit[k] = 0; mIdle[k] = 0;
            eReq[k] = 0; ePulse[k] = 0; eRej[k] = 0; eBusy[k] = 0;
        end
    endtask

    // Applies the vending rules to one instance for one clock edge.
    task automatic modelStep(input int k, input logic a, input logic b, input logic c,
                             input logic rdy, input logic done);
        int acc  = 0;
        int rej  = 0;
        int next = mPhase[k];
        ePulse[k] = 0;
        if (mPhase[k] == P_IDLE || mPhase[k] == P_COLLECT) begin
            if (a) begin
                if (mCredit[k] + 1 <= MAXC) begin mCredit[k] += 1; acc = 1; end
                else rej = 1;
            end
            if (b) begin
                if (mCredit[k] + 2 <= MAXC) begin mCredit[k] += 2; acc = 1; end
                else rej = 1;
            end
        end else if (a || b) begin
            rej = 1;
        end
        case (mPhase[k])
            P_IDLE: if (acc != 0) begin next = P_COLLECT; mIdle[k] = 0; end
            P_COLLECT: begin
                if (c) next = P_REFUND;
                else if (mCredit[k] >= price[k]) next = P_VEND;
                else if (acc == 0 && mIdle[k] == TOUT - 1) next = P_REFUND;
                mIdle[k] = (acc != 0) ? 0 : mIdle[k] + 1;
                if (next != P_COLLECT) mIdle[k] = 0;
            end
            P_VEND: if (rdy) begin mCredit[k] -= price[k]; next = P_WAIT; end
            P_WAIT: if (done) next = (mCredit[k] > 0) ? P_REFUND : P_IDLE;
            default: begin
                if (mCredit[k] > 0) begin mCredit[k] -= 1; ePulse[k] = 1; end
                else next = P_IDLE;
            end
        endcase
        mPhase[k] = next;
        eRej[k]  = rej;
        eReq[k]  = (next == P_VEND) ? 1 : 0;
        eBusy[k] = (next == P_VEND || next == P_WAIT || next == P_REFUND) ? 1 : 0;
    endtask

    task automatic checkOutput();
        check("req0",    {7'd0, req0},    8'(eReq[0]));
        check("pulse0",  {7'd0, pulse0},  8'(ePulse[0]));
        check("reject0", {7'd0, rej0},    8'(eRej[0]));
        check("busy0",   {7'd0, busy0},   8'(eBusy[0]));
        check("credit0", {5'd0, credit0}, 8'(mCredit[0]));
        check("req1",    {7'd0, req1},    8'(eReq[1]));
        check("pulse1",  {7'd0, pulse1},  8'(ePulse[1]));
        check("reject1", {7'd0, rej1},    8'(eRej[1]));
        check("busy1",   {7'd0, busy1},   8'(eBusy[1]));
        check("credit1", {5'd0, credit1}, 8'(mCredit[1]));
        pulseSeen += int'(pulse0);
        reqSeen   += int'(req0);
        rejSeen   += int'(rej0);
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic c,
                                 input logic rdy, input logic done);
        coin_a = a; coin_b = b; cancel = c; disp_ready = rdy; disp_done = done;
        @(posedge clock);
        for (int k = 0; k < 2; k++) modelStep(k, a, b, c, rdy, done);
        #1;
        checkOutput();
    endtask

    task automatic idleSteps(input int n, input logic rdy, input logic done);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, rdy, done);
    endtask

    task automatic clearSeen();
        pulseSeen = 0; reqSeen = 0; rejSeen = 0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_req"},    {7'd0, req0 | req1},     8'd0);
        check({tag, "_pulse"},  {7'd0, pulse0 | pulse1}, 8'd0);
        check({tag, "_reject"}, {7'd0, rej0 | rej1},     8'd0);
        check({tag, "_busy"},   {7'd0, busy0 | busy1},   8'd0);
        check({tag, "_credit"}, {5'd0, credit0 | credit1}, 8'd0);
    endtask

    initial begin
        modelReset();
        clearSeen();
        repeat (3) @(posedge clock);
        #1;
        checkAllZero("reset");
        reset = 1'b1;
        idleSteps(2, 1'b0, 1'b0);

        // Four single coins reach the price; the dispenser takes the request at once.
        clearSeen();
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idleSteps(2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idleSteps(2, 1'b0, 1'b0);
        check("s1_req_cycles", 8'(reqSeen), 8'd1);
        check("s1_pulses", 8'(pulseSeen), 8'd0);

        // Two coin_b reach the price; the third arrives during VEND and is refused.
        clearSeen();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idleSteps(2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idleSteps(12, 1'b0, 1'b0);
        check("s2_rejects", 8'(rejSeen), 8'd1);
        check("s2_credit_end", {5'd0, credit0}, 8'd0);

        // Credit 3 then cancel returns exactly three change pulses.
        clearSeen();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleSteps(6, 1'b0, 1'b0);
        check("s3_pulses", 8'(pulseSeen), 8'd3);
        check("s3_busy_end", {7'd0, busy0}, 8'd0);

        // Credit 2 left alone times out into a refund of two pulses.
        clearSeen();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleSteps(TOUT + 6, 1'b0, 1'b0);
        check("s4_pulses", 8'(pulseSeen), 8'd2);

        // Coin_a and coin_b together at credit 6 on the PRICE 7 instance: b is refused.
        clearSeen();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s5_credit1_max", {5'd0, credit1}, 8'd7);
        idleSteps(3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idleSteps(12, 1'b0, 1'b0);

        // Stall in VEND, then pull reset mid-cycle: outputs drop without waiting for an edge.
        clearSeen();
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idleSteps(20, 1'b0, 1'b0);
        check("s6_req_held", {7'd0, req0}, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("async_reset");
        modelReset();
        @(posedge clock);
        #1;
        checkAllZero("reset_hold");
        reset = 1'b1;
        idleSteps(3, 1'b0, 1'b0);
        check("s6_pulses", 8'(pulseSeen), 8'd0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 29) == 0), ($urandom_range(0, 1) == 0),
                          ($urandom_range(0, 3) == 0));
            if (($urandom_range(0, 199) == 0) && (i > 0)) idleSteps(TOUT + 10, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
